ps2_device_tx: RTL and testbench

PS/2 device-side transmitter: emulates a keyboard by serialising bytes from a small internal FIFO onto `ps2_clk`/`ps2_data` using the device-to-host frame format. It is the opposite end of the `ps2_keyboard` receiver. It is placed in the keyboard experiment's simulation top or test harness to drive scan codes (make/break sequences) into the receiver and `keyboard_controller` without a physical keyboard. Both lines are driven push-pull; host-to-device inhibit/request is out of scope.

---
 rtl/ps2_device_tx.sv | 110 +++++++++++
 tb/tb_ps2_device_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// ps2_device_tx: PS/2 device-to-host frame transmitter fed from a small byte FIFO.
// Emulates a keyboard by serialising queued scan codes onto push-pull ps2_clk/ps2_data.
module ps2_device_tx #(
    parameter int CLK_DIV = 8,
    parameter int GAP     = 16,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       full,
    output logic       ovf,
    output logic       busy,
    output logic       ps2_clk,
    output logic       ps2_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_DIV > GAP ? CLK_DIV : GAP) + 1;
    localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rptr, wptr;
    logic [AW:0]   count, count_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    idx, idx_n;
    logic [10:0]   sh, sh_n;
    logic [7:0]    head;
    logic          push, pop, clk_n, data_n;

    assign push    = wr_en && !full;
    assign pop     = (state == S_IDLE) && (count != '0);
    assign head    = mem[rptr];
    assign count_n = count + (AW+1)'(push) - (AW+1)'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sh_n    = sh;
        case (state)
            S_IDLE: if (pop) begin
                state_n = S_HIGH;
                cnt_n   = '0;
                idx_n   = '0;
                sh_n    = {1'b1, ~^head, head, 1'b0};
            end
            S_HIGH: begin
                state_n = (cnt == DIV_END) ? S_LOW : S_HIGH;
                cnt_n   = (cnt == DIV_END) ? '0 : cnt + 1'b1;
            end
            S_LOW: if (cnt == DIV_END) begin
                cnt_n   = '0;
                state_n = (idx == 4'd10) ? S_GAP : S_HIGH;
                idx_n   = (idx == 4'd10) ? idx : idx + 1'b1;
                sh_n    = (idx == 4'd10) ? sh : {1'b1, sh[10:1]};
            end else begin
                cnt_n   = cnt + 1'b1;
            end
            S_GAP: begin
                state_n = (cnt == GAP_END) ? S_IDLE : S_GAP;
                cnt_n   = (cnt == GAP_END) ? '0 : cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
        // data only moves on entry to HIGH, so it is stable across every low phase
        clk_n  = state_n != S_LOW;
        data_n = (state_n == S_HIGH || state_n == S_LOW) ? sh_n[0] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            sh       <= '1;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            ovf      <= 1'b0;
            busy     <= 1'b0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            idx      <= idx_n;
            sh       <= sh_n;
            rptr     <= pop ? rptr + 1'b1 : rptr;
            wptr     <= push ? wptr + 1'b1 : wptr;
            count    <= count_n;
            full     <= count_n == FULL_CNT;
            ovf      <= ovf || (wr_en && full);
            busy     <= (state_n != S_IDLE) || (count_n != '0);
            ps2_clk  <= clk_n;
            ps2_data <= data_n;
        end
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// tb_ps2_device_tx: randomized scoreboard bench; frames decoded off the PS/2 lines are
// checked against a queue-and-timer model of the FIFO and transmitter occupancy.
module tb_ps2_device_tx;
    localparam int CLK_DIV = 8;
    localparam int GAP     = 16;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 22 * CLK_DIV + GAP;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, ovf, busy, ps2_clk, ps2_data;

    ps2_device_tx #(.CLK_DIV(CLK_DIV), .GAP(GAP), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .ovf(ovf), .busy(busy), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         t;
    } frame_t;

    logic [7:0] mq[$];
    frame_t     fq[$];
    frame_t     nf;
    int         cyc = 0;
    int         tx_left = 0;
    int         s0;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         movf = 0;

    bit          in_frame = 0;
    bit          pc = 1;
    bit          pd = 1;
    int          nbits = 0;
    int          low_len = 0;
    int          start_cyc = 0;
    logic [10:0] bits;

    task automatic chk(input string n, input int a, input int e);
        n_cmp++;
        if (a != e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Reference model: FIFO as a queue, transmitter as an occupancy timer of
    // one frame plus gap; the next pop is possible one idle cycle later.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            fq.delete();
            tx_left = 0;
            movf = 0;
        end else begin
            s0 = mq.size();
            if (wr_en && s0 == DEPTH) movf = 1;
            if (tx_left > 0) tx_left--;
            else if (s0 > 0) begin
                nf.b = mq.pop_front();
                nf.t = cyc;
                fq.push_back(nf);
                tx_left = FRAME;
            end
            if (wr_en && s0 < DEPTH) mq.push_back(wr_data);
        end
    end

    task automatic end_frame();
        frame_t f;
        chk("frame_expected", int'(fq.size() > 0), 1);
        if (fq.size() > 0) begin
            f = fq.pop_front();
            chk("start_cycle", start_cyc, f.t);
            chk("frame_len", cyc - start_cyc, 22 * CLK_DIV);
            chk("start_bit", bits[0], 0);
            chk("data", bits[8:1], f.b);
            chk("parity", bits[9], ~^f.b);
            chk("stop_bit", bits[10], 1);
        end
    endtask

    // Monitor: samples on the falling clk edge, decodes frames off the wire.
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 0;
            pc = 1;
            pd = 1;
        end else begin
            chk("full", full, int'(mq.size() == DEPTH));
            chk("ovf", ovf, movf);
            chk("busy", busy, int'(tx_left > 0 || mq.size() > 0));
            if (!in_frame && pc && ps2_clk && pd && !ps2_data) begin
                in_frame = 1;
                nbits = 0;
                start_cyc = cyc;
            end
            if (!pc && !ps2_clk) chk("data_stable_low", ps2_data, pd);
            if (pc && !ps2_clk) begin
                chk("clk_fall_in_frame", in_frame, 1);
                if (in_frame && nbits < 11) begin
                    bits[nbits] = ps2_data;
                    nbits++;
                end
                low_len = 0;
            end
            if (!ps2_clk) low_len++;
            if (!pc && ps2_clk && in_frame) begin
                chk("low_len", low_len, CLK_DIV);
                if (nbits == 11) begin
                    end_frame();
                    in_frame = 0;
                end
            end
            pc = ps2_clk;
            pd = ps2_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1;
        wr_data = b;
        tick();
        wr_en = 0;
    endtask

    task automatic drain();
        int k = 0;
        while ((mq.size() > 0 || fq.size() > 0 || tx_left > 0 || in_frame) && k < 4000) begin
            tick();
            k++;
        end
        chk("drain_timeout", int'(k < 4000), 1);
        repeat (5) tick();
    endtask

    task automatic do_reset_check();
        rst = 1;
        #1;
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst = 0;
    endtask

    task automatic wait_bits(input int nb);
        int k = 0;
        while (!(in_frame && nbits == nb && !ps2_clk) && k < 3000) begin
            tick();
            k++;
        end
        chk("wait_bits_timeout", int'(k < 3000), 1);
    endtask

    initial begin
        tick();
        do_reset_check();
        repeat (3) tick();
        wr(8'h1C);
        drain();
        wr(8'h00);
        wr(8'hFF);
        drain();
        wr(8'hF0);
        wr(8'h1C);
        drain();
        for (int i = 0; i < 5; i++) wr(8'(8'h11 + i));
        drain();
        wr(8'hA0);
        repeat (3) tick();
        for (int i = 0; i < 5; i++) wr(8'(8'h21 + i));
        repeat (500) tick();
        wait_bits(5);
        do_reset_check();
        repeat (300) tick();
        wr(8'h3C);
        wait_bits(8);
        wr(8'hC3);
        drain();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset_check();
            else if ($urandom_range(0, 99) < 3) wr(8'($urandom));
            else tick();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
